multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 57 +++++
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/multicycle_ctrl.sv | 120 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes,
// ALU operation codes and datapath mux selects.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Opcode/handshake inputs and datapath control outputs of the controller.
interface multicycle_ctrl_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic       illegal;

    modport ctrl (
        input  op, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b,
               pc_source, alu_op, state, illegal
    );

    modport dp (
        output op, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b,
               pc_source, alu_op, state, illegal
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU main controller: Moore FSM sequencing fetch, decode and
// per-instruction execute steps, with memory waits on MemReady.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.ctrl   bus_io
);

    state_e state_q, state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Outputs are gated by rst_n so that FETCH's MemRead is not driven during reset.
    always_comb begin
        state_d = S_FETCH;
        ctrl    = '0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALUOP_ADD;
                    ctrl.pc_source = PCSRC_ALU;
                    ctrl.ir_write  = bus_io.mem_ready;
                    ctrl.pc_write  = bus_io.mem_ready;
                    state_d        = bus_io.mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    ctrl.alu_src_b = SRCB_IMM_SH;
                    ctrl.alu_op    = ALUOP_ADD;
                    case (bus_io.op)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_R:         state_d = S_EXEC;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_J:         state_d = S_JUMP;
                        OP_ADDI:      state_d = S_ADDIEX;
                        default: begin
                            state_d      = S_FETCH;
                            ctrl.illegal = 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALUOP_ADD;
                    state_d        = (bus_io.op == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.iord     = 1'b1;
                    state_d       = bus_io.mem_ready ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.iord      = 1'b1;
                    state_d        = bus_io.mem_ready ? S_FETCH : S_MEMWR;
                end
                S_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.alu_op    = ALUOP_FUNCT;
                    state_d        = S_RWB;
                end
                S_RWB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_REG;
                    ctrl.alu_op        = ALUOP_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_JUMP;
                end
                S_ADDIEX: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALUOP_ADD;
                    state_d        = S_ADDIWB;
                end
                S_ADDIWB: begin
                    ctrl.reg_write = 1'b1;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign bus_io.pc_write      = ctrl.pc_write;
    assign bus_io.pc_write_cond = ctrl.pc_write_cond;
    assign bus_io.iord          = ctrl.iord;
    assign bus_io.mem_read      = ctrl.mem_read;
    assign bus_io.mem_write     = ctrl.mem_write;
    assign bus_io.ir_write      = ctrl.ir_write;
    assign bus_io.mem_to_reg    = ctrl.mem_to_reg;
    assign bus_io.reg_write     = ctrl.reg_write;
    assign bus_io.reg_dst       = ctrl.reg_dst;
    assign bus_io.alu_src_a     = ctrl.alu_src_a;
    assign bus_io.alu_src_b     = ctrl.alu_src_b;
    assign bus_io.pc_source     = ctrl.pc_source;
    assign bus_io.alu_op        = ctrl.alu_op;
    assign bus_io.illegal       = ctrl.illegal;
    assign bus_io.state         = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction streams checked cycle by cycle against an
// instruction-level model of the controller's state path and outputs.
module tb_multicycle_ctrl;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_ADDI = 6'b001000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus();
    multicycle_ctrl dut (.clk(clk), .rst_n(rst_n), .bus_io(bus));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic is_legal(input logic [5:0] op);
        return op == T_R || op == T_LW || op == T_SW || op == T_BEQ || op == T_J || op == T_ADDI;
    endfunction

    // {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, srca, srcb[2], pcsrc[2], aluop[3], ill}
    function automatic logic [17:0] outs_now();
        return {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.reg_write, bus.reg_dst, bus.alu_src_a,
                bus.alu_src_b, bus.pc_source, bus.alu_op, bus.illegal};
    endfunction

    function automatic logic [17:0] model(input int st, input logic mr, input logic [5:0] op);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, srca, ill;
        logic [1:0] srcb, pcsrc;
        logic [2:0] aop;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, srca, ill} = '0;
        srcb = 2'b00; pcsrc = 2'b00; aop = 3'b000;
        case (st)
            0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            1:  begin srcb = 2'b11; ill = !is_legal(op); end
            2:  begin srca = 1; srcb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin srca = 1; aop = 3'b010; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin srca = 1; aop = 3'b001; pcwc = 1; pcsrc = 2'b01; end
            9:  begin pcw = 1; pcsrc = 2'b10; end
            10: begin srca = 1; srcb = 2'b10; end
            11: begin rw = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, srca, srcb, pcsrc, aop, ill};
    endfunction

    task automatic step(input int st, input logic mr, input logic [5:0] op, input string tag);
        @(negedge clk);
        bus.mem_ready = mr;
        bus.op = op;
        #1;
        chk({tag, " state"}, 32'(bus.state), 32'(st));
        chk({tag, " outs"}, 32'(outs_now()), 32'(model(st, mr, op)));
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Path per instruction: FETCH(waits), DECODE, then the opcode's execute steps.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input string tag);
        for (int i = 0; i < fw; i++) step(0, 1'b0, 6'($urandom), {tag, " fetch-wait"});
        step(0, 1'b1, 6'($urandom), {tag, " fetch"});
        step(1, rbit(), op, {tag, " decode"});
        case (op)
            T_LW: begin
                step(2, rbit(), op, {tag, " memadr"});
                for (int i = 0; i < mw; i++) step(3, 1'b0, op, {tag, " memrd-wait"});
                step(3, 1'b1, op, {tag, " memrd"});
                step(4, rbit(), op, {tag, " memwb"});
            end
            T_SW: begin
                step(2, rbit(), op, {tag, " memadr"});
                for (int i = 0; i < mw; i++) step(5, 1'b0, op, {tag, " memwr-wait"});
                step(5, 1'b1, op, {tag, " memwr"});
            end
            T_R: begin
                step(6, rbit(), op, {tag, " exec"});
                step(7, rbit(), op, {tag, " rwb"});
            end
            T_ADDI: begin
                step(10, rbit(), op, {tag, " addiex"});
                step(11, rbit(), op, {tag, " addiwb"});
            end
            T_BEQ: step(8, rbit(), op, {tag, " branch"});
            T_J:   step(9, rbit(), op, {tag, " jump"});
            default: ;
        endcase
    endtask

    task automatic check_in_reset(input string tag);
        #1;
        chk({tag, " state"}, 32'(bus.state), 32'd0);
        chk({tag, " outs"}, 32'(outs_now()), 32'd0);
    endtask

    logic [5:0] ops [6] = '{T_R, T_LW, T_SW, T_BEQ, T_J, T_ADDI};
    logic [5:0] rop;

    initial begin
        bus.op = 6'd0;
        bus.mem_ready = 1'b1;
        check_in_reset("reset");
        @(negedge clk);
        check_in_reset("reset-clocked");
        @(negedge clk);
        bus.mem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("first-fetch state", 32'(bus.state), 32'd0);
        chk("first-fetch outs", 32'(outs_now()), 32'(model(0, 1'b0, 6'd0)));

        run_instr(T_LW, 0, 0, "lw");
        run_instr(T_SW, 0, 3, "sw-wait3");
        run_instr(T_R, 2, 0, "r-fetchwait2");
        run_instr(T_BEQ, 0, 0, "beq");
        run_instr(T_J, 0, 0, "j");
        run_instr(T_ADDI, 1, 0, "addi");
        run_instr(6'b111111, 0, 0, "illegal");

        // Reset pulsed between edges during a MEMRD wait.
        step(0, 1'b1, 6'd0, "rst-mid fetch");
        step(1, 1'b0, T_LW, "rst-mid decode");
        step(2, 1'b0, T_LW, "rst-mid memadr");
        step(3, 1'b0, T_LW, "rst-mid memrd-wait");
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        check_in_reset("rst-mid async");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.mem_ready = 1'b1;
            check_in_reset("rst-mid held");
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rst-mid release state", 32'(bus.state), 32'd0);
        chk("rst-mid release outs", 32'(outs_now()), 32'(model(0, 1'b0, bus.op)));

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do rop = 6'($urandom); while (is_legal(rop));
            end else begin
                rop = ops[$urandom_range(0, 5)];
            end
            run_instr(rop, $urandom_range(0, 3), $urandom_range(0, 3), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
